// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver feeding a first-word-fall-through byte FIFO
// Each serial bit is sampled once, mid-bit; only frames with good stop and parity are pushed.
module uart_rx_fifo #(
    parameter int clocks_per_bit = 3,
    parameter int data_bits      = 8,
    parameter int parity_mode    = 0,
    parameter int stop_bits      = 1,
    parameter int fifo_depth     = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ser_rx,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    output logic [$clog2(fifo_depth):0]   fifo_count
);
    localparam int AW = $clog2(fifo_depth);
    localparam int CW = $clog2(clocks_per_bit + 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(clocks_per_bit / 2);
    localparam logic [CW-1:0] CNT_FULL  = CW'(clocks_per_bit);
    localparam logic [2:0]    LAST_DATA = 3'(data_bits - 1);
    localparam logic [2:0]    LAST_STOP = 3'(stop_bits - 1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   OCC_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   OCC_FULL  = (AW+1)'(fifo_depth);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q;
    logic          rx_s;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_bad_q, par_bad_d;
    logic          stop_bad_q, stop_bad_d;
    logic          push;
    logic          frame_err_q, frame_err_d;
    logic          parity_err_q, parity_err_d;
    logic          overrun_q, overrun_d;

    logic [7:0]    mem_q [fifo_depth];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    data_q, data_d;
    logic          full, pop, wr_en;

    assign rx_s = sync_q[1];
    assign tick = (cnt_q == CNT_ONE);

    always_comb begin
        state_d      = state_q;
        cnt_d        = tick ? CNT_FULL : cnt_q - CNT_ONE;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        par_bad_d    = par_bad_q;
        stop_bad_d   = stop_bad_q;
        push         = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = CNT_HALF;
                if (!rx_s) state_d = START;
            end
            START: if (tick) begin
                bit_d      = '0;
                shreg_d    = '0;
                par_bad_d  = 1'b0;
                stop_bad_d = 1'b0;
                state_d    = rx_s ? IDLE : DATA;
            end
            DATA: if (tick) begin
                shreg_d[bit_q] = rx_s;
                if (bit_q == LAST_DATA) begin
                    bit_d   = '0;
                    state_d = (parity_mode != 0) ? PARITY : STOP;
                end else begin
                    bit_d = bit_q + 3'd1;
                end
            end
            PARITY: if (tick) begin
                // Odd mode wants an odd number of ones over data plus parity bit.
                par_bad_d = (parity_mode == 1) ? ~(^shreg_q ^ rx_s) : (^shreg_q ^ rx_s);
                state_d   = STOP;
            end
            STOP: if (tick) begin
                if (bit_q != LAST_STOP) begin
                    stop_bad_d = stop_bad_q | ~rx_s;
                    bit_d      = bit_q + 3'd1;
                end else if (stop_bad_q | ~rx_s) begin
                    frame_err_d = 1'b1;
                    state_d     = BREAK;
                end else if (par_bad_q) begin
                    parity_err_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            BREAK: if (rx_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign full      = (count_q == OCC_FULL);
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    assign wr_en     = push & (~full | pop);
    assign overrun_d = push & full & ~pop;

    // The head byte is registered so it can hold its last value once the FIFO drains.
    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (wr_en && !pop)      count_d = count_q + OCC_ONE;
        else if (pop && !wr_en) count_d = count_q - OCC_ONE;
        data_d = data_q;
        if (count_d != '0) data_d = (wr_en && rd_ptr_d == wr_ptr_q) ? shreg_q : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= shreg_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= 2'b11;
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shreg_q      <= '0;
            par_bad_q    <= 1'b0;
            stop_bad_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            data_q       <= '0;
        end else begin
            sync_q       <= {sync_q[0], ser_rx};
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shreg_q      <= shreg_d;
            par_bad_q    <= par_bad_d;
            stop_bad_q   <= stop_bad_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            data_q       <= data_d;
        end
    end

    assign out_data   = data_q;
    assign fifo_count = count_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed checks for uart_rx_fifo
// Unit a runs the defaults (8N1, depth 4); unit b runs even parity.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    localparam int CPB     = 3;
    localparam int LAT_MAX = 10 * CPB + 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_a = 1'b1, rdy_a = 1'b0, rx_b = 1'b1, rdy_b = 1'b1;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b, fe_a, fe_b, pe_a, pe_b, ov_a, ov_b;
    logic [2:0] cnt_a, cnt_b;

    uart_rx_fifo u_dut_a (
        .clk(clk), .rst_n(rst_n), .ser_rx(rx_a), .out_data(data_a), .out_valid(valid_a),
        .out_ready(rdy_a), .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a), .fifo_count(cnt_a)
    );

    uart_rx_fifo #(.parity_mode(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .ser_rx(rx_b), .out_data(data_b), .out_valid(valid_b),
        .out_ready(rdy_b), .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b), .fifo_count(cnt_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] pops_a[$], pops_b[$];
    int lat_a[$];
    int t_start_a = 0;
    int fe_a_n = 0, pe_a_n = 0, ov_a_n = 0, vcyc_a = 0;
    int fe_b_n = 0, pe_b_n = 0, ov_b_n = 0;

    always @(negedge clk) begin
        if (valid_a && rdy_a) begin
            pops_a.push_back(data_a);
            lat_a.push_back(cyc - t_start_a);
        end
        if (valid_b && rdy_b) pops_b.push_back(data_b);
        if (valid_a) vcyc_a <= vcyc_a + 1;
        if (fe_a) fe_a_n <= fe_a_n + 1;
        if (pe_a) pe_a_n <= pe_a_n + 1;
        if (ov_a) ov_a_n <= ov_a_n + 1;
        if (fe_b) fe_b_n <= fe_b_n + 1;
        if (pe_b) pe_b_n <= pe_b_n + 1;
        if (ov_b) ov_b_n <= ov_b_n + 1;
    end

    int n_vec = 0, n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input bit unit, input logic v);
        if (unit) rx_b = v;
        else      rx_a = v;
        tick(CPB);
    endtask

    task automatic send_frame(input bit unit, input logic [7:0] d, input bit has_par,
                              input logic par, input logic stop);
        if (!unit) t_start_a = cyc;
        drive_bit(unit, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(unit, d[i]);
        if (has_par) drive_bit(unit, par);
        drive_bit(unit, stop);
    endtask

    task automatic idle(input bit unit, input int n);
        if (unit) rx_b = 1'b1;
        else      rx_a = 1'b1;
        tick(n);
    endtask

    task automatic expect_pop(input bit unit, input string tag, input logic [7:0] exp, input bit check_lat);
        int n;
        n = unit ? pops_b.size() : pops_a.size();
        chk({tag, "_avail"}, n, 1);
        if (n > 0) begin
            if (unit) chk({tag, "_data"}, pops_b.pop_front(), exp);
            else begin
                chk({tag, "_data"}, pops_a.pop_front(), exp);
                if (check_lat) chk({tag, "_lat"}, lat_a[lat_a.size()-1] <= LAT_MAX, 1);
            end
        end
    endtask

    initial begin
        tick(3);
        chk("rst_valid", valid_a, 0);
        chk("rst_data", data_a, 0);
        chk("rst_count", cnt_a, 0);
        chk("rst_pulses", {fe_a, pe_a, ov_a}, 0);
        rst_n = 1'b1;
        tick(4);

        // 8N1 back-to-back bytes with the consumer always ready
        rdy_a = 1'b1;
        send_frame(0, 8'h48, 0, 1'b0, 1'b1);
        idle(0, 8);
        expect_pop(0, "8n1_b0", 8'h48, 1);
        send_frame(0, 8'h0A, 0, 1'b0, 1'b1);
        idle(0, 8);
        expect_pop(0, "8n1_b1", 8'h0A, 1);
        chk("8n1_valid_cycles", vcyc_a, 2);
        chk("8n1_errors", fe_a_n + pe_a_n + ov_a_n, 0);

        // Bad stop bit followed by a long low line
        send_frame(0, 8'hC3, 0, 1'b0, 1'b0);
        tick(40);
        chk("brk_fe", fe_a_n, 1);
        chk("brk_pe", pe_a_n, 0);
        chk("brk_nopush", pops_a.size(), 0);
        chk("brk_count", cnt_a, 0);
        idle(0, 6);
        send_frame(0, 8'h55, 0, 1'b0, 1'b1);
        idle(0, 8);
        expect_pop(0, "brk_next", 8'h55, 1);
        chk("brk_fe_after", fe_a_n, 1);

        // One-cycle glitch at idle
        rx_a = 1'b0;
        tick(1);
        rx_a = 1'b1;
        tick(20);
        chk("glitch_nopush", pops_a.size(), 0);
        chk("glitch_errors", {fe_a_n[7:0], pe_a_n[7:0]}, 16'h0100);
        send_frame(0, 8'h3C, 0, 1'b0, 1'b1);
        idle(0, 8);
        expect_pop(0, "glitch_next", 8'h3C, 1);

        // Fill a depth-4 FIFO with five bytes while the consumer stalls
        rdy_a = 1'b0;
        for (int b = 1; b <= 5; b++) begin
            send_frame(0, 8'(b), 0, 1'b0, 1'b1);
            idle(0, 4);
        end
        chk("ovr_count", cnt_a, 4);
        chk("ovr_pulses", ov_a_n, 1);
        chk("ovr_head_valid", valid_a, 1);
        chk("ovr_head_data", data_a, 8'h01);
        rdy_a = 1'b1;
        tick(8);
        chk("ovr_drained", pops_a.size(), 4);
        for (int b = 1; b <= 4; b++) begin
            if (pops_a.size() > 0) chk($sformatf("ovr_pop%0d", b), pops_a.pop_front(), b);
        end
        chk("ovr_empty_count", cnt_a, 0);
        chk("ovr_hold_data", data_a, 8'h04);
        chk("ovr_empty_valid", valid_a, 0);

        // Reset asserted in the middle of the data bits of 0xA5
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        rst_n = 1'b0;
        tick(2);
        rx_a = 1'b1;
        tick(1);
        chk("rst_mid_data", data_a, 0);
        rst_n = 1'b1;
        tick(12);
        chk("rst_mid_nopush", pops_a.size(), 0);
        chk("rst_mid_count", cnt_a, 0);
        chk("rst_mid_errors", {fe_a_n[7:0], pe_a_n[7:0], ov_a_n[7:0]}, 24'h010001);
        send_frame(0, 8'h5A, 0, 1'b0, 1'b1);
        idle(0, 8);
        expect_pop(0, "rst_mid_next", 8'h5A, 1);

        // Even parity unit: 0x31 has three ones, so the parity bit must be 1
        send_frame(1, 8'h31, 1, 1'b0, 1'b1);
        idle(1, 8);
        chk("par_bad_pe", pe_b_n, 1);
        chk("par_bad_nopush", pops_b.size(), 0);
        chk("par_bad_count", cnt_b, 0);
        chk("par_bad_fe", fe_b_n, 0);
        send_frame(1, 8'h31, 1, 1'b1, 1'b1);
        idle(1, 8);
        expect_pop(1, "par_good", 8'h31, 0);
        send_frame(1, 8'h31, 1, 1'b0, 1'b0);
        idle(1, 8);
        chk("par_both_fe", fe_b_n, 1);
        chk("par_both_pe", pe_b_n, 1);
        chk("par_both_nopush", pops_b.size(), 0);
        send_frame(1, 8'h80, 1, 1'b1, 1'b1);
        idle(1, 8);
        expect_pop(1, "par_next", 8'h80, 0);
        chk("par_overrun", ov_b_n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
